// File: rtl/tank_render_pkg.sv
// Shared codes and helpers for the tank sprite ROM scheduler.
package tank_render_pkg;

  typedef enum logic [3:0] {
    CAT_NONE   = 4'd0,
    CAT_WALL   = 4'd1,
    CAT_TANK   = 4'd2,
    CAT_BULLET = 4'd3
  } category_e;

  typedef enum logic [2:0] {
    DIR_LEFT  = 3'd0,
    DIR_RIGHT = 3'd1,
    DIR_UP    = 3'd2,
    DIR_DOWN  = 3'd3
  } direction_e;

  localparam int SPR_W_DEF = 32;
  localparam int ADDR_W    = 10;

  // Enemy pointer walks 1..n_tank-1; slot 0 is the player and is never rotated in.
  function automatic logic [2:0] rr_next(input logic [2:0] ptr, input int n_tank);
    if (ptr >= 3'(n_tank - 1)) return 3'd1;
    return ptr + 3'd1;
  endfunction

endpackage

// File: rtl/tank_render_arbiter_rr_arbiter.sv
// Round-robin priority encoder: first asserted request at or after ptr, wrapping.
module rr_arbiter #(
  parameter int M  = 3,
  parameter int IW = 2
) (
  input  logic [M-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [IW-1:0] gnt,
  output logic          any
);

  logic [2*M-1:0] dbl;
  logic [M-1:0]   rot;
  int             off;
  int             sum;

  always_comb begin
    dbl = {req, req} >> ptr;
    rot = dbl[M-1:0];
    off = 0;
    any = 1'b0;
    // Descending scan so the lowest rotated offset wins.
    for (int k = M - 1; k >= 0; k--) begin
      if (rot[k]) begin
        off = k;
        any = 1'b1;
      end
    end
    sum = int'(ptr) + off;
    if (sum >= M) sum = sum - M;
    gnt = IW'(sum);
  end

endmodule

// File: rtl/tank_render_arbiter.sv
// Two-stage per-pixel scheduler for the shared tank sprite ROM address path.
// Optional RENDER_STATS_EN adds overlap_cnt: overlap pixels of the previous frame.
module tank_render_arbiter
  import tank_render_pkg::*;
#(
  parameter int N_TANK  = 4,
  parameter int SPR_W   = SPR_W_DEF,
  parameter int COORD_W = 10
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [COORD_W-1:0]        pixel_x,
  input  logic [COORD_W-1:0]        pixel_y,
  input  logic                      pixel_valid,
  input  logic                      frame_start,
  input  logic [N_TANK*COORD_W-1:0] tank_x,
  input  logic [N_TANK*COORD_W-1:0] tank_y,
  input  logic [N_TANK*3-1:0]       tank_dir,
  input  logic [N_TANK-1:0]         tank_alive,
  input  logic                      wall_hit,
  input  logic                      bullet_hit,
  output logic [3:0]                category,
  output logic [ADDR_W-1:0]         addr,
  output logic [2:0]                tank_direct,
  output logic                      player_tank,
  output logic [2:0]                grant_id,
`ifdef RENDER_STATS_EN
  output logic [15:0]               overlap_cnt,
`endif
  output logic                      overlap
);

  localparam int DW  = $clog2(SPR_W);
  localparam int IDW = $clog2(N_TANK);
  localparam int EW  = N_TANK - 1;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Stage 0: unsigned offset hit test; pixels left of/above a tank wrap large and miss.
  logic [COORD_W-1:0] ddx_p0 [N_TANK];
  logic [COORD_W-1:0] ddy_p0 [N_TANK];
  logic [N_TANK-1:0]  hit_p0;

  always_comb begin
    for (int i = 0; i < N_TANK; i++) begin
      ddx_p0[i] = pixel_x - tank_x[i*COORD_W +: COORD_W];
      ddy_p0[i] = pixel_y - tank_y[i*COORD_W +: COORD_W];
      hit_p0[i] = tank_alive[i] && (ddx_p0[i] < COORD_W'(SPR_W))
                                && (ddy_p0[i] < COORD_W'(SPR_W));
    end
  end

  // Stage 1: registered hits and sprite offsets.
  logic [N_TANK-1:0] hit_p1;
  logic              vld_p1;
  logic              fs_p1;
  logic              wall_p1;
  logic              bullet_p1;
  logic [DW-1:0]     dx_p1  [N_TANK];
  logic [DW-1:0]     dy_p1  [N_TANK];
  logic [2:0]        dir_p1 [N_TANK];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_p1 <= '0;
      vld_p1 <= 1'b0;
      fs_p1  <= 1'b0;
    end else begin
      hit_p1 <= hit_p0;
      vld_p1 <= pixel_valid;
      fs_p1  <= frame_start;
    end
  end

  always_ff @(posedge clk) begin
    wall_p1   <= wall_hit;
    bullet_p1 <= bullet_hit;
    for (int i = 0; i < N_TANK; i++) begin
      dx_p1[i]  <= ddx_p0[i][DW-1:0];
      dy_p1[i]  <= ddy_p0[i][DW-1:0];
      dir_p1[i] <= tank_dir[i*3 +: 3];
    end
  end

  // Stage 2: arbitration; the frame_start pixel already uses the new frame's pointer.
  logic [2:0]        rr_ptr;
  logic [2:0]        ptr_eff;
  logic              overlap_seen;
  logic              ovl_p1;
  logic              any_hit_p1;
  logic              enemy_any;
  logic [IDW-1:0]    enemy_ptr;
  logic [IDW-1:0]    enemy_gnt;
  logic [IDW-1:0]    gid_p1;
  category_e         cat_p1;
  logic [ADDR_W-1:0] addr_p1;

  rr_arbiter #(
    .M  (EW),
    .IW (IDW)
  ) u_rr (
    .req (hit_p1[N_TANK-1:1]),
    .ptr (enemy_ptr),
    .gnt (enemy_gnt),
    .any (enemy_any)
  );

  always_comb begin
    ovl_p1     = $countones(hit_p1) > 1;
    ptr_eff    = (fs_p1 && overlap_seen) ? rr_next(rr_ptr, N_TANK) : rr_ptr;
    enemy_ptr  = IDW'(ptr_eff - 3'd1);
    any_hit_p1 = hit_p1[0] | enemy_any;
    gid_p1     = hit_p1[0] ? '0 : IDW'(enemy_gnt + 1'b1);

    cat_p1 = CAT_NONE;
    if (!vld_p1)         cat_p1 = CAT_NONE;
    else if (bullet_p1)  cat_p1 = CAT_BULLET;
    else if (any_hit_p1) cat_p1 = CAT_TANK;
    else if (wall_p1)    cat_p1 = CAT_WALL;

    addr_p1 = ADDR_W'(int'(dy_p1[gid_p1]) * SPR_W + int'(dx_p1[gid_p1]));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      category     <= CAT_NONE;
      addr         <= '0;
      tank_direct  <= '0;
      player_tank  <= 1'b0;
      grant_id     <= '0;
      overlap      <= 1'b0;
      rr_ptr       <= 3'd1;
      overlap_seen <= 1'b0;
    end else begin
      category <= cat_p1;
      if (cat_p1 == CAT_TANK) begin
        addr        <= addr_p1;
        tank_direct <= dir_p1[gid_p1];
        player_tank <= (gid_p1 == '0);
        grant_id    <= 3'(gid_p1);
      end else begin
        addr        <= '0;
        tank_direct <= '0;
        player_tank <= 1'b0;
        grant_id    <= '0;
      end
      overlap      <= ovl_p1;
      rr_ptr       <= ptr_eff;
      overlap_seen <= (overlap_seen && !fs_p1) || ovl_p1;
    end
  end

`ifdef RENDER_STATS_EN
  logic [15:0] ovl_run;

  // The frame_start pixel's own overlap belongs to the frame it opens.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovl_run     <= '0;
      overlap_cnt <= '0;
    end else if (fs_p1) begin
      overlap_cnt <= ovl_run;
      ovl_run     <= {15'd0, ovl_p1};
    end else if (ovl_p1) begin
      ovl_run     <= sat_inc16(ovl_run);
    end
  end
`endif

endmodule

// File: tb/tb_tank_render_arbiter.sv
// Bench for tank_render_arbiter: pixel-level reference model plus directed literals.
module tb_tank_render_arbiter;

  localparam int N  = 4;
  localparam int CW = 10;
  localparam int SW = 32;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [CW-1:0]   pixel_x, pixel_y;
  logic            pixel_valid, frame_start;
  logic [N*CW-1:0] tank_x, tank_y;
  logic [N*3-1:0]  tank_dir;
  logic [N-1:0]    tank_alive;
  logic            wall_hit, bullet_hit;
  logic [3:0]      category;
  logic [9:0]      addr;
  logic [2:0]      tank_direct;
  logic            player_tank;
  logic [2:0]      grant_id;
  logic            overlap;
`ifdef RENDER_STATS_EN
  logic [15:0]     overlap_cnt;
`endif

  always #5 clk = ~clk;

  tank_render_arbiter #(.N_TANK(N), .SPR_W(SW), .COORD_W(CW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pixel_x     (pixel_x),
    .pixel_y     (pixel_y),
    .pixel_valid (pixel_valid),
    .frame_start (frame_start),
    .tank_x      (tank_x),
    .tank_y      (tank_y),
    .tank_dir    (tank_dir),
    .tank_alive  (tank_alive),
    .wall_hit    (wall_hit),
    .bullet_hit  (bullet_hit),
    .category    (category),
    .addr        (addr),
    .tank_direct (tank_direct),
    .player_tank (player_tank),
    .grant_id    (grant_id),
`ifdef RENDER_STATS_EN
    .overlap_cnt (overlap_cnt),
`endif
    .overlap     (overlap)
  );

  typedef struct packed {
    logic [3:0]  cat;
    logic [9:0]  addr;
    logic [2:0]  dir;
    logic        pl;
    logic [2:0]  gid;
    logic        ovl;
    logic [15:0] cnt;
  } exp_t;

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t exp_mid  = '0;
  exp_t exp_out  = '0;
  int   m_ptr    = 1;
  bit   m_seen   = 1'b0;
  int   m_cnt    = 0;
  int   m_lat    = 0;

  // Reference: evaluate one pixel from the rules, updating the frame bookkeeping in order.
  task automatic model_step(output exp_t e);
    int  dxs [N];
    int  dys [N];
    bit  h   [N];
    int  nh, g, j, ex, ey;
    nh = 0;
    for (int i = 0; i < N; i++) begin
      ex = (int'(pixel_x) - int'(tank_x[i*CW +: CW]) + 1024) % 1024;
      ey = (int'(pixel_y) - int'(tank_y[i*CW +: CW]) + 1024) % 1024;
      h[i]   = tank_alive[i] && ex < SW && ey < SW;
      dxs[i] = ex;
      dys[i] = ey;
      if (h[i]) nh++;
    end
    if (frame_start) begin
      if (m_seen) m_ptr = (m_ptr == N - 1) ? 1 : m_ptr + 1;
      m_seen = 1'b0;
      m_lat  = m_cnt;
      m_cnt  = 0;
    end
    g = -1;
    if (h[0]) g = 0;
    else begin
      for (int k = 0; k < N - 1; k++) begin
        j = 1 + ((m_ptr - 1 + k) % (N - 1));
        if (g < 0 && h[j]) g = j;
      end
    end
    if (nh > 1) begin
      m_seen = 1'b1;
      if (m_cnt < 65535) m_cnt++;
    end
    e = '0;
    e.ovl = (nh > 1);
    if (!pixel_valid)   e.cat = 4'd0;
    else if (bullet_hit) e.cat = 4'd3;
    else if (g >= 0)    e.cat = 4'd2;
    else if (wall_hit)  e.cat = 4'd1;
    else                e.cat = 4'd0;
    if (e.cat == 4'd2) begin
      e.addr = 10'(dys[g] * SW + dxs[g]);
      e.dir  = tank_dir[g*3 +: 3];
      e.pl   = (g == 0);
      e.gid  = 3'(g);
    end
`ifdef RENDER_STATS_EN
    e.cnt = 16'(m_lat);
`endif
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ptr   = 1;
      m_seen  = 1'b0;
      m_cnt   = 0;
      m_lat   = 0;
      exp_mid = '0;
      exp_out = '0;
    end else begin
      exp_out = exp_mid;
      model_step(exp_mid);
    end
  end

  exp_t act;
  always @(negedge clk) begin
    act = '0;
    act.cat  = category;
    act.addr = addr;
    act.dir  = tank_direct;
    act.pl   = player_tank;
    act.gid  = grant_id;
    act.ovl  = overlap;
`ifdef RENDER_STATS_EN
    act.cnt  = overlap_cnt;
`endif
    n_checks++;
    if (act !== exp_out) begin
      n_fail++;
      $display("FAIL pipe_cmp t=%0t actual cat=%0d addr=%0d dir=%0d pl=%0d gid=%0d ovl=%0d cnt=%0d required cat=%0d addr=%0d dir=%0d pl=%0d gid=%0d ovl=%0d cnt=%0d",
               $time, act.cat, act.addr, act.dir, act.pl, act.gid, act.ovl, act.cnt,
               exp_out.cat, exp_out.addr, exp_out.dir, exp_out.pl, exp_out.gid, exp_out.ovl, exp_out.cnt);
    end
  end

  task automatic chk(input string nm, input int actual, input int required);
    n_checks++;
    if (actual !== required) begin
      n_fail++;
      $display("FAIL %s actual=%0d required=%0d", nm, actual, required);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    pixel_valid = 1'b0;
    frame_start = 1'b0;
    wall_hit    = 1'b0;
    bullet_hit  = 1'b0;
    pixel_x     = 10'd1000;
    pixel_y     = 10'd1000;
  endtask

  task automatic set_tank(input int i, input int x, input int y, input int d, input bit a);
    tank_x[i*CW +: CW] = CW'(x);
    tank_y[i*CW +: CW] = CW'(y);
    tank_dir[i*3 +: 3] = 3'(d);
    tank_alive[i]      = a;
  endtask

  // Drive one pixel, then idle until its result sits on the outputs.
  task automatic probe(input int x, input int y, input bit v, input bit w, input bit b);
    pixel_x     = CW'(x);
    pixel_y     = CW'(y);
    pixel_valid = v;
    wall_hit    = w;
    bullet_hit  = b;
    step();
    idle();
    step();
  endtask

  task automatic frame_pulse();
    idle();
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
  endtask

  initial begin
    rst_n      = 1'b0;
    tank_x     = '0;
    tank_y     = '0;
    tank_dir   = '0;
    tank_alive = '0;
    idle();
    repeat (3) step();
    chk("rst_category", category, 0);
    chk("rst_grant", grant_id, 0);
    rst_n = 1'b1;
    step();

    set_tank(1, 100, 50, 2, 1'b1);
    probe(103, 52, 1'b1, 1'b0, 1'b0);
    chk("single_cat", category, 2);
    chk("single_addr", addr, 67);
    chk("single_dir", tank_direct, 2);
    chk("single_player", player_tank, 0);
    chk("single_gid", grant_id, 1);

    set_tank(0, 190, 190, 3, 1'b1);
    set_tank(2, 185, 195, 1, 1'b1);
    probe(200, 200, 1'b1, 1'b0, 1'b0);
    chk("player_gid", grant_id, 0);
    chk("player_flag", player_tank, 1);
    chk("player_ovl", overlap, 1);
    chk("player_addr", addr, 330);

    set_tank(0, 190, 190, 3, 1'b0);
    set_tank(1, 300, 100, 0, 1'b1);
    set_tank(2, 310, 110, 1, 1'b1);
    frame_pulse();
    probe(320, 120, 1'b1, 1'b0, 1'b0);
    chk("rr_f1_gid", grant_id, 2);
    chk("rr_f1_addr", addr, 330);
    frame_pulse();
    probe(320, 120, 1'b1, 1'b0, 1'b0);
    chk("rr_f2_gid", grant_id, 1);
    chk("rr_f2_addr", addr, 660);
    frame_pulse();
    probe(320, 120, 1'b1, 1'b0, 1'b0);
    chk("rr_f3_gid", grant_id, 1);
    frame_pulse();
    probe(320, 120, 1'b1, 1'b0, 1'b0);
    chk("rr_f4_gid", grant_id, 2);

    probe(320, 120, 1'b1, 1'b0, 1'b1);
    chk("bullet_cat", category, 3);
    chk("bullet_addr", addr, 0);
    probe(320, 120, 1'b0, 1'b0, 1'b0);
    chk("invalid_cat", category, 0);
    chk("invalid_ovl", overlap, 1);
    probe(299, 120, 1'b1, 1'b1, 1'b0);
    chk("left_miss_cat", category, 1);
    chk("left_miss_ovl", overlap, 0);

    pixel_x = 10'd320; pixel_y = 10'd120; pixel_valid = 1'b1;
    step();
    rst_n = 1'b0;
    #1;
    chk("midrst_cat", category, 0);
    chk("midrst_ovl", overlap, 0);
    idle();
    step();
    rst_n = 1'b1;
    step();
    chk("postrst_cat", category, 0);
    probe(320, 120, 1'b1, 1'b0, 1'b0);
    chk("postrst_gid", grant_id, 1);

`ifdef RENDER_STATS_EN
    frame_pulse();
    for (int i = 0; i < 37; i++) begin
      pixel_x = 10'd320; pixel_y = 10'd120; pixel_valid = 1'b1;
      step();
    end
    frame_pulse();
    step();
    step();
    chk("stats_cnt", overlap_cnt, 37);
`endif

    for (int c = 0; c < 3000; c++) begin
      bit wrap;
      rst_n = ($urandom_range(0, 999) == 0) ? 1'b0 : 1'b1;
      frame_start = ($urandom_range(0, 39) == 0);
      if (frame_start) begin
        for (int i = 0; i < N; i++) begin
          wrap = ($urandom_range(0, 7) == 0);
          set_tank(i, wrap ? $urandom_range(1000, 1023) : $urandom_range(0, 60),
                   $urandom_range(0, 60), $urandom_range(0, 3), $urandom_range(0, 3) != 0);
        end
      end
      pixel_x     = CW'($urandom_range(0, 100));
      pixel_y     = CW'($urandom_range(0, 100));
      pixel_valid = ($urandom_range(0, 3) != 0);
      wall_hit    = ($urandom_range(0, 3) == 0);
      bullet_hit  = ($urandom_range(0, 7) == 0);
      step();
    end

    rst_n = 1'b1;
    idle();
    repeat (3) step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
